// File: rtl/uart_hex_parser_if.sv
// Byte-in / value-out bundle for the UART hex parser: receive strobe, parsed-value
// valid/ready handshake, error report and busy status.
interface uart_hex_parser_if #(
    parameter int DIGITS = 2
);
    localparam int W  = 4 * DIGITS;
    localparam int CW = $clog2(DIGITS + 1);

    logic          in_valid;
    logic [7:0]    in_data;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [CW-1:0] out_count;
    logic          err_valid;
    logic [1:0]    err_code;
    logic          busy;

    modport master (
        output in_valid, in_data, out_ready,
        input  out_valid, out_data, out_count, err_valid, err_code, busy
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output out_valid, out_data, out_count, err_valid, err_code, busy
    );
endinterface

// File: rtl/uart_hex_parser.sv
// Assembles ASCII hex digits from the UART receive stream into a binary value and
// presents it on a valid/ready port when the line terminator arrives.
module uart_hex_parser #(
    parameter int         DIGITS    = 2,
    parameter logic [7:0] TERM_CHAR = 8'd13
) (
    input  logic             clk,
    input  logic             reset,
    uart_hex_parser_if.slave bus
);
    localparam int W  = 4 * DIGITS;
    localparam int CW = $clog2(DIGITS + 1);

    localparam logic [1:0] ST_ACCUM   = 2'd0;
    localparam logic [1:0] ST_DISCARD = 2'd1;
    localparam logic [1:0] ST_HOLD    = 2'd2;

    localparam logic [1:0] CLS_DIGIT   = 2'd0;
    localparam logic [1:0] CLS_IGNORE  = 2'd1;
    localparam logic [1:0] CLS_TERM    = 2'd2;
    localparam logic [1:0] CLS_INVALID = 2'd3;

    localparam logic [1:0] ERR_INVALID  = 2'd1;
    localparam logic [1:0] ERR_OVERFLOW = 2'd2;
    localparam logic [1:0] ERR_DROPPED  = 2'd3;

    localparam logic [CW-1:0] CNT_MAX = CW'(DIGITS);

    // The terminator is tested first so a TERM_CHAR overlapping another class still ends the line.
    function automatic logic [1:0] char_class(input logic [7:0] c);
        logic [1:0] cls;
        if (c == TERM_CHAR) begin
            cls = CLS_TERM;
        end else if ((c >= 8'h30 && c <= 8'h39) ||
                     (c >= 8'h41 && c <= 8'h46) ||
                     (c >= 8'h61 && c <= 8'h66)) begin
            cls = CLS_DIGIT;
        end else if (c == 8'h20 || c == 8'h0A) begin
            cls = CLS_IGNORE;
        end else begin
            cls = CLS_INVALID;
        end
        return cls;
    endfunction

    function automatic logic [3:0] hex_nibble(input logic [7:0] c);
        logic [3:0] n;
        if (c <= 8'h39) begin
            n = c[3:0];
        end else begin
            n = c[3:0] + 4'd9;
        end
        return n;
    endfunction

    logic [1:0]    state_q,     state_d;
    logic [W-1:0]  acc_q,       acc_d;
    logic [CW-1:0] cnt_q,       cnt_d;
    logic          out_valid_q, out_valid_d;
    logic [W-1:0]  out_data_q,  out_data_d;
    logic [CW-1:0] out_count_q, out_count_d;
    logic          err_valid_q, err_valid_d;
    logic [1:0]    err_code_q,  err_code_d;

    logic          handshake_s;
    logic          line_open_s;
    logic [W-1:0]  acc_base_s;
    logic [CW-1:0] cnt_base_s;
    logic [1:0]    cls_s;
    logic [3:0]    nibble_s;

    assign handshake_s = (state_q == ST_HOLD) && bus.out_ready;
    // A byte arriving with the handshake starts a fresh line (zero-bubble).
    assign line_open_s = (state_q == ST_ACCUM) || handshake_s;
    assign acc_base_s  = handshake_s ? {W{1'b0}} : acc_q;
    assign cnt_base_s  = handshake_s ? {CW{1'b0}} : cnt_q;
    assign cls_s       = char_class(bus.in_data);
    assign nibble_s    = hex_nibble(bus.in_data);

    // Next-state logic for the line FSM, accumulator and output/error registers.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_count_d = out_count_q;
        err_valid_d = 1'b0;
        err_code_d  = err_code_q;

        case (state_q)
            ST_HOLD: begin
                if (handshake_s) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_ACCUM;
                    acc_d       = {W{1'b0}};
                    cnt_d       = {CW{1'b0}};
                end else if (bus.in_valid) begin
                    err_valid_d = 1'b1;
                    err_code_d  = ERR_DROPPED;
                end else begin
                    err_valid_d = 1'b0;
                end
            end
            ST_DISCARD: begin
                if (bus.in_valid && (cls_s == CLS_TERM)) begin
                    state_d = ST_ACCUM;
                    acc_d   = {W{1'b0}};
                    cnt_d   = {CW{1'b0}};
                end else begin
                    state_d = ST_DISCARD;
                end
            end
            ST_ACCUM: begin
                state_d = ST_ACCUM;
            end
            default: begin
                state_d     = ST_ACCUM;
                acc_d       = {W{1'b0}};
                cnt_d       = {CW{1'b0}};
                out_valid_d = 1'b0;
            end
        endcase

        if (bus.in_valid && line_open_s) begin
            case (cls_s)
                CLS_DIGIT: begin
                    if (cnt_base_s < CNT_MAX) begin
                        acc_d = (acc_base_s << 4) | W'(nibble_s);
                        cnt_d = cnt_base_s + CW'(1);
                    end else begin
                        err_valid_d = 1'b1;
                        err_code_d  = ERR_OVERFLOW;
                        state_d     = ST_DISCARD;
                    end
                end
                CLS_TERM: begin
                    if (cnt_base_s != {CW{1'b0}}) begin
                        out_data_d  = acc_base_s;
                        out_count_d = cnt_base_s;
                        out_valid_d = 1'b1;
                        acc_d       = {W{1'b0}};
                        cnt_d       = {CW{1'b0}};
                        state_d     = ST_HOLD;
                    end else begin
                        state_d = ST_ACCUM;
                    end
                end
                CLS_INVALID: begin
                    err_valid_d = 1'b1;
                    err_code_d  = ERR_INVALID;
                    state_d     = ST_DISCARD;
                end
                CLS_IGNORE: begin
                    acc_d = acc_d;
                end
                default: begin
                    state_d = ST_DISCARD;
                end
            endcase
        end else begin
            acc_d = acc_d;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_ACCUM;
            acc_q       <= {W{1'b0}};
            cnt_q       <= {CW{1'b0}};
            out_valid_q <= 1'b0;
            out_data_q  <= {W{1'b0}};
            out_count_q <= {CW{1'b0}};
            err_valid_q <= 1'b0;
            err_code_q  <= 2'd0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_count_q <= out_count_d;
            err_valid_q <= err_valid_d;
            err_code_q  <= err_code_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_count = out_count_q;
    assign bus.err_valid = err_valid_q;
    assign bus.err_code  = err_code_q;
    assign bus.busy      = (state_q != ST_ACCUM) || (cnt_q != {CW{1'b0}});
endmodule

// File: tb/tb_uart_hex_parser.sv
// Directed bench for uart_hex_parser: expected values queued as lines are typed,
// popped and compared when the parser presents them.
module tb_uart_hex_parser;
    localparam int DIGITS = 2;

    typedef struct packed {
        logic [7:0] data;
        logic [1:0] count;
    } exp_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    exp_t sb_q[$];

    uart_hex_parser_if #(.DIGITS(DIGITS)) bus ();

    uart_hex_parser #(
        .DIGITS    (DIGITS),
        .TERM_CHAR (8'd13)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one byte for exactly one clock; returns at the negedge after it was sampled.
    task automatic send(input logic [7:0] b);
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
    endtask

    task automatic expect_line(input logic [7:0] d, input logic [1:0] c);
        exp_t e;
        e.data  = d;
        e.count = c;
        sb_q.push_back(e);
    endtask

    task automatic check_out(input string tag);
        exp_t e;
        chk({tag, "_valid"}, 16'(bus.out_valid), 16'h0001);
        chk({tag, "_sb_nonempty"}, 16'(sb_q.size() > 0), 16'h0001);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk({tag, "_data"},  16'(bus.out_data),  16'(e.data));
            chk({tag, "_count"}, 16'(bus.out_count), 16'(e.count));
        end
    endtask

    task automatic accept();
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_out_valid"}, 16'(bus.out_valid), 16'h0000);
        chk({tag, "_out_data"},  16'(bus.out_data),  16'h0000);
        chk({tag, "_out_count"}, 16'(bus.out_count), 16'h0000);
        chk({tag, "_err_valid"}, 16'(bus.err_valid), 16'h0000);
        chk({tag, "_err_code"},  16'(bus.err_code),  16'h0000);
        chk({tag, "_busy"},      16'(bus.busy),      16'h0000);
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        reset         = 1'b1;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'h35;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("byte_during_reset_ignored", 16'(bus.busy), 16'h0000);

        // "4f" CR, held for ten cycles, then accepted
        send(8'h34);
        chk("busy_after_digit", 16'(bus.busy), 16'h0001);
        send(8'h66);
        send(8'h0D);
        expect_line(8'h4F, 2'd2);
        check_out("line_4f");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold_valid", 16'(bus.out_valid), 16'h0001);
            chk("hold_data",  16'(bus.out_data),  16'h004F);
            chk("hold_count", 16'(bus.out_count), 16'h0002);
        end
        accept();
        chk("accept_valid_low", 16'(bus.out_valid), 16'h0000);
        chk("accept_busy_low",  16'(bus.busy),      16'h0000);

        // "7" CR with ready high: one-cycle valid; blank line gives nothing
        bus.out_ready = 1'b1;
        send(8'h37);
        send(8'h0D);
        expect_line(8'h07, 2'd1);
        check_out("line_7");
        @(negedge clk);
        chk("line_7_one_cycle", 16'(bus.out_valid), 16'h0000);
        send(8'h0D);
        chk("blank_line_no_out", 16'(bus.out_valid), 16'h0000);
        chk("blank_line_busy",   16'(bus.busy),      16'h0000);
        bus.out_ready = 1'b0;

        // "123" overflows, then "Ab" parses
        send(8'h31);
        send(8'h32);
        send(8'h33);
        chk("overflow_err_valid", 16'(bus.err_valid), 16'h0001);
        chk("overflow_err_code",  16'(bus.err_code),  16'h0002);
        @(negedge clk);
        chk("overflow_pulse_once", 16'(bus.err_valid), 16'h0000);
        chk("overflow_code_kept",  16'(bus.err_code),  16'h0002);
        chk("discard_busy",        16'(bus.busy),      16'h0001);
        send(8'h0D);
        chk("overflow_no_out", 16'(bus.out_valid), 16'h0000);
        chk("overflow_idle",   16'(bus.busy),      16'h0000);
        send(8'h41);
        send(8'h62);
        send(8'h0D);
        expect_line(8'hAB, 2'd2);
        check_out("line_ab");
        accept();
        chk("line_ab_accepted", 16'(bus.out_valid), 16'h0000);

        // "G5" CR: invalid char, rest of line silently dropped
        send(8'h47);
        chk("invalid_err_valid", 16'(bus.err_valid), 16'h0001);
        chk("invalid_err_code",  16'(bus.err_code),  16'h0001);
        send(8'h35);
        chk("discard_no_err", 16'(bus.err_valid), 16'h0000);
        chk("discard_busy2",  16'(bus.busy),      16'h0001);
        send(8'h0D);
        chk("invalid_no_out",     16'(bus.out_valid), 16'h0000);
        chk("invalid_busy_falls", 16'(bus.busy),      16'h0000);

        // HOLD: dropped byte, then zero-bubble byte on the handshake
        send(8'h34);
        send(8'h46);
        send(8'h0D);
        expect_line(8'h4F, 2'd2);
        check_out("hold_4f");
        send(8'h39);
        chk("dropped_err_valid", 16'(bus.err_valid), 16'h0001);
        chk("dropped_err_code",  16'(bus.err_code),  16'h0003);
        chk("dropped_keeps_out", 16'(bus.out_data),  16'h004F);
        chk("dropped_keeps_vld", 16'(bus.out_valid), 16'h0001);
        bus.out_ready = 1'b1;
        send(8'h33);
        bus.out_ready = 1'b0;
        chk("bubble_valid_low", 16'(bus.out_valid), 16'h0000);
        chk("bubble_no_err",    16'(bus.err_valid), 16'h0000);
        chk("bubble_busy",      16'(bus.busy),      16'h0001);
        send(8'h0D);
        expect_line(8'h03, 2'd1);
        check_out("line_bubble_3");
        accept();

        // ignored characters inside a line, lowercase digit
        send(8'h20);
        send(8'h63);
        send(8'h0A);
        send(8'h31);
        send(8'h0D);
        expect_line(8'hC1, 2'd2);
        check_out("line_c1");
        accept();

        // reset mid-line discards the partial value
        send(8'h35);
        reset = 1'b1;
        @(negedge clk);
        check_reset_values("midline_reset");
        reset = 1'b0;
        send(8'h0D);
        chk("after_reset_no_out", 16'(bus.out_valid), 16'h0000);
        chk("after_reset_idle",   16'(bus.busy),      16'h0000);

        // reset while holding a value drops it
        send(8'h32);
        send(8'h0D);
        expect_line(8'h02, 2'd1);
        check_out("line_2");
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_reset_values("hold_reset");

        chk("scoreboard_drained", 16'(sb_q.size()), 16'h0000);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
